// File: rtl/axi_lite_sram.sv
// AXI-lite slave memory with independent read/write FSMs and fixed programmable latencies.
// Backing store is an internal word array aliased every 2**STORE_AW words inside the legal window.
module axi_lite_sram #(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                READ_LATENCY  = 1,
  parameter int                WRITE_LATENCY = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] MEM_SIZE      = 32'h0800_0000,
  parameter int                STORE_AW      = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);
  localparam int                SW     = DATA_W / 8;
  localparam logic [ADDR_W:0]   WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0]   WIN_HI = WIN_LO + {1'b0, MEM_SIZE};
  localparam logic [3:0]        RLAT   = 4'(READ_LATENCY);
  localparam logic [3:0]        WLAT   = 4'(WRITE_LATENCY);
  localparam logic [1:0]        OKAY   = 2'b00;
  localparam logic [1:0]        SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
  typedef enum logic [1:0] {W_COLLECT, W_WAIT, W_RESP} wstate_t;

  // Window compare is one bit wider so BASE_ADDR+MEM_SIZE cannot wrap.
  function automatic logic in_win(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
  endfunction

  logic [DATA_W-1:0] mem [2**STORE_AW];

  logic live;
  rstate_t rstate, rstate_nxt;
  wstate_t wstate, wstate_nxt;
  logic [3:0] rcnt, rcnt_nxt, wcnt, wcnt_nxt;
  logic [ADDR_W-1:0] raddr_q, awaddr_q, ar_al, aw_al, r_addr, w_addr;
  logic [DATA_W-1:0] wdata_q, w_data, w_merged, r_word;
  logic [SW-1:0] wstrb_q, w_strb;
  logic aw_full, w_full, aw_full_nxt, w_full_nxt;
  logic ar_hs, aw_hs, w_hs, r_access, w_commit, w_we;
  logic [STORE_AW-1:0] r_idx, w_idx;

  assign ar_al = araddr & ~(ADDR_W'(3));
  assign aw_al = awaddr & ~(ADDR_W'(3));

  assign arready = live && (rstate == R_IDLE);
  assign rvalid  = (rstate == R_RESP);
  assign awready = live && (wstate == W_COLLECT) && !aw_full;
  assign wready  = live && (wstate == W_COLLECT) && !w_full;
  assign bvalid  = (wstate == W_RESP);

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live   <= 1'b0;
      rstate <= R_IDLE;
      wstate <= W_COLLECT;
      rcnt   <= '0;
      wcnt   <= '0;
    end else begin
      live   <= 1'b1;
      rstate <= rstate_nxt;
      wstate <= wstate_nxt;
      rcnt   <= rcnt_nxt;
      wcnt   <= wcnt_nxt;
    end
  end

  // With zero latency the access happens on the AR handshake edge itself.
  always_comb begin
    rstate_nxt = rstate;
    rcnt_nxt   = rcnt;
    r_access   = 1'b0;
    r_addr     = raddr_q;
    case (rstate)
      R_IDLE: begin
        if (ar_hs) begin
          r_addr = ar_al;
          if (RLAT == 4'd0) begin
            r_access   = 1'b1;
            rstate_nxt = R_RESP;
          end else begin
            rcnt_nxt   = RLAT;
            rstate_nxt = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        rcnt_nxt = rcnt - 4'd1;
        if (rcnt == 4'd1) begin
          r_access   = 1'b1;
          rstate_nxt = R_RESP;
        end
      end
      R_RESP: if (rready) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // Operands bypass the buffers when the completing handshake is this cycle.
  assign w_addr = aw_full ? awaddr_q : aw_al;
  assign w_data = w_full ? wdata_q : wdata;
  assign w_strb = w_full ? wstrb_q : wstrb;

  always_comb begin
    wstate_nxt  = wstate;
    wcnt_nxt    = wcnt;
    w_commit    = 1'b0;
    aw_full_nxt = aw_full || aw_hs;
    w_full_nxt  = w_full || w_hs;
    case (wstate)
      W_COLLECT: begin
        if ((aw_full || aw_hs) && (w_full || w_hs)) begin
          if (WLAT == 4'd0) begin
            w_commit    = 1'b1;
            aw_full_nxt = 1'b0;
            w_full_nxt  = 1'b0;
            wstate_nxt  = W_RESP;
          end else begin
            wcnt_nxt   = WLAT;
            wstate_nxt = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        wcnt_nxt = wcnt - 4'd1;
        if (wcnt == 4'd1) begin
          w_commit    = 1'b1;
          aw_full_nxt = 1'b0;
          w_full_nxt  = 1'b0;
          wstate_nxt  = W_RESP;
        end
      end
      W_RESP: if (bready) wstate_nxt = W_COLLECT;
      default: wstate_nxt = W_COLLECT;
    endcase
  end

  assign w_idx = w_addr[STORE_AW+1:2];
  assign r_idx = r_addr[STORE_AW+1:2];
  assign w_we  = w_commit && in_win(w_addr);

  always_comb begin
    w_merged = mem[w_idx];
    for (int b = 0; b < SW; b++) begin
      if (w_strb[b]) w_merged[b*8 +: 8] = w_data[b*8 +: 8];
    end
  end

  // A coinciding commit to the same word is seen by the read.
  assign r_word = (w_we && (w_idx == r_idx)) ? w_merged : mem[r_idx];

  always_ff @(posedge clk) begin
    if (w_we) mem[w_idx] <= w_merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      raddr_q  <= '0;
      rdata    <= '0;
      rresp    <= OKAY;
      bresp    <= OKAY;
    end else begin
      aw_full <= aw_full_nxt;
      w_full  <= w_full_nxt;
      if (aw_hs) awaddr_q <= aw_al;
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (ar_hs) raddr_q <= ar_al;
      if (r_access) begin
        if (in_win(r_addr)) begin
          rdata <= r_word;
          rresp <= OKAY;
        end else begin
          rdata <= '0;
          rresp <= SLVERR;
        end
      end
      if (w_commit) bresp <= in_win(w_addr) ? OKAY : SLVERR;
    end
  end
endmodule

// File: tb/tb_axi_lite_sram.sv
// Directed bench: transaction table on a 2/1-latency instance plus hand sequences, and a 0/0 instance.
module tb_axi_lite_sram;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] araddr, awaddr, wdata, rdata, z_araddr, z_awaddr, z_wdata, z_rdata;
  logic [3:0]  wstrb, z_wstrb;
  logic [1:0]  rresp, bresp, z_rresp, z_bresp;
  logic arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic z_arvalid, z_arready, z_rvalid, z_rready, z_awvalid, z_awready, z_wvalid, z_wready;
  logic z_bvalid, z_bready;

  axi_lite_sram #(.READ_LATENCY(2), .WRITE_LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  axi_lite_sram #(.READ_LATENCY(0), .WRITE_LATENCY(0)) u_z (
    .clk(clk), .rst_n(rst_n),
    .araddr(z_araddr), .arvalid(z_arvalid), .arready(z_arready),
    .rdata(z_rdata), .rresp(z_rresp), .rvalid(z_rvalid), .rready(z_rready),
    .awaddr(z_awaddr), .awvalid(z_awvalid), .awready(z_awready),
    .wdata(z_wdata), .wstrb(z_wstrb), .wvalid(z_wvalid), .wready(z_wready),
    .bresp(z_bresp), .bvalid(z_bvalid), .bready(z_bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                         output int lat);
    int t0, g;
    araddr = a; arvalid = 1'b1; g = 0;
    while (!arready && g < 40) begin @(negedge clk); g++; end
    t0 = cyc;
    @(negedge clk); arvalid = 1'b0; g = 0;
    while (!rvalid && g < 40) begin @(negedge clk); g++; end
    check("rd_timeout", 32'(g < 40), 32'd1);
    lat = cyc - t0; d = rdata; r = rresp;
    @(negedge clk);
    check("arready_after_r", 32'(arready), 32'd1);
    check("rvalid_after_r", 32'(rvalid), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] r, output int lat);
    int t_last, g;
    bit aw_done, w_done, haw, hw;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 0; w_done = 0; t_last = cyc; g = 0;
    while (!(aw_done && w_done) && g < 40) begin
      haw = awvalid && awready; hw = wvalid && wready;
      if (haw) begin aw_done = 1; t_last = cyc; end
      if (hw) begin w_done = 1; t_last = cyc; end
      @(negedge clk); g++;
      if (haw) awvalid = 1'b0;
      if (hw) wvalid = 1'b0;
    end
    g = 0;
    while (!bvalid && g < 40) begin @(negedge clk); g++; end
    check("wr_timeout", 32'(g < 40), 32'd1);
    lat = cyc - t_last; r = bresp;
    @(negedge clk);
    check("awready_after_b", 32'(awready), 32'd1);
    check("wready_after_b", 32'(wready), 32'd1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  task automatic reset_vals(input string tag);
    check({tag, "_arready"}, 32'(arready), 32'd0);
    check({tag, "_awready"}, 32'(awready), 32'd0);
    check({tag, "_wready"}, 32'(wready), 32'd0);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    check({tag, "_bvalid"}, 32'(bvalid), 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_rresp"}, 32'(rresp), 32'd0);
    check({tag, "_bresp"}, 32'(bresp), 32'd0);
  endtask

  initial begin
    logic [31:0] d, held;
    logic [1:0] r;
    int lat, t0, g;

    vecs.push_back('{1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00});
    vecs.push_back('{1, 32'h8000_0010, 32'hAABB_CCDD, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{0, 32'h8000_0013, 32'h0, 4'h0, 32'hAABB_CCDD, 2'b00});
    vecs.push_back('{1, 32'h8000_0004, 32'h0123_4567, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{1, 32'h8000_0004, 32'hFFFF_FFFF, 4'h0, 32'h0, 2'b00});
    vecs.push_back('{0, 32'h8000_0004, 32'h0, 4'h0, 32'h0123_4567, 2'b00});
    vecs.push_back('{1, 32'h87FF_FFFC, 32'h5A5A_5A5A, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{0, 32'h87FF_FFFC, 32'h0, 4'h0, 32'h5A5A_5A5A, 2'b00});
    vecs.push_back('{0, 32'h0000_1000, 32'h0, 4'h0, 32'h0, 2'b10});
    vecs.push_back('{0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 2'b10});
    vecs.push_back('{1, 32'h8800_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 2'b10});
    vecs.push_back('{0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00});

    rst_n = 1'b0;
    araddr = '0; arvalid = 0; rready = 1; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0;
    wvalid = 0; bready = 1;
    z_araddr = '0; z_arvalid = 0; z_rready = 1; z_awaddr = '0; z_awvalid = 0; z_wdata = '0;
    z_wstrb = '0; z_wvalid = 0; z_bready = 1;
    repeat (3) @(negedge clk);
    reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_arready", 32'(arready), 32'd1);
    check("post_rst_awready", 32'(awready), 32'd1);
    check("post_rst_wready", 32'(wready), 32'd1);

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, lat);
        check($sformatf("v%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
        check($sformatf("v%0d_wlat", i), 32'(lat), 32'd2);
      end else begin
        do_read(vecs[i].addr, d, r, lat);
        check($sformatf("v%0d_rdata", i), d, vecs[i].exp_data);
        check($sformatf("v%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
        check($sformatf("v%0d_rlat", i), 32'(lat), 32'd3);
      end
    end

    // Reset while a write sits in W_WAIT: outputs clear at once, write is dropped.
    awaddr = 32'h8000_0000; wdata = 32'h0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    check("mid_aw_ready", 32'(awready && wready), 32'd1);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    check("mid_no_bvalid", 32'(bvalid), 32'd0);
    rst_n = 1'b0;
    #1;
    reset_vals("async");
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_bvalid", 32'(bvalid), 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mid_post_bvalid", 32'(bvalid), 32'd0);
    end
    do_read(32'h8000_0000, d, r, lat);
    check("mid_mem_unchanged", d, 32'hDEAD_BEEF);

    // W three cycles ahead of AW, partial strobes merge into the old word.
    wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1;
    check("wfirst_wready", 32'(wready), 32'd1);
    @(negedge clk);
    wvalid = 0;
    check("wfirst_wready_full", 32'(wready), 32'd0);
    check("wfirst_awready", 32'(awready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    awaddr = 32'h8000_0010; awvalid = 1;
    t0 = cyc;
    @(negedge clk);
    awvalid = 0; g = 0;
    while (!bvalid && g < 40) begin @(negedge clk); g++; end
    check("wfirst_blat", 32'(cyc - t0), 32'd2);
    check("wfirst_bresp", 32'(bresp), 32'd0);
    @(negedge clk);
    do_read(32'h8000_0010, d, r, lat);
    check("wfirst_merged", d, 32'hAA22_CC44);

    // R backpressure with a second AR waiting.
    rready = 0;
    araddr = 32'h8000_0000; arvalid = 1;
    @(negedge clk);
    araddr = 32'h8000_0010; g = 0;
    while (!rvalid && g < 40) begin @(negedge clk); g++; end
    held = rdata;
    check("bp_first_data", held, 32'hDEAD_BEEF);
    repeat (4) begin
      @(negedge clk);
      check("bp_rvalid", 32'(rvalid), 32'd1);
      check("bp_rdata", rdata, 32'hDEAD_BEEF);
      check("bp_rresp", 32'(rresp), 32'd0);
      check("bp_arready", 32'(arready), 32'd0);
    end
    rready = 1;
    @(negedge clk);
    check("bp_arready_back", 32'(arready), 32'd1);
    t0 = cyc;
    @(negedge clk);
    arvalid = 0; g = 0;
    while (!rvalid && g < 40) begin @(negedge clk); g++; end
    check("bp_second_lat", 32'(cyc - t0), 32'd3);
    check("bp_second_data", rdata, 32'hAA22_CC44);
    @(negedge clk);

    // Zero-latency instance: read access and write commit on the same edge.
    z_awaddr = 32'h8000_0020; z_wdata = 32'h0BAD_0BAD; z_wstrb = 4'hF;
    z_awvalid = 1; z_wvalid = 1;
    check("z_ready", 32'(z_awready && z_wready), 32'd1);
    @(negedge clk);
    z_awvalid = 0; z_wvalid = 0;
    check("z_bvalid1", 32'(z_bvalid), 32'd1);
    check("z_bresp1", 32'(z_bresp), 32'd0);
    @(negedge clk);
    check("z_awready_back", 32'(z_awready), 32'd1);
    z_araddr = 32'h8000_0020; z_arvalid = 1;
    z_wdata = 32'h600D_F00D; z_awvalid = 1; z_wvalid = 1;
    check("z_arready", 32'(z_arready), 32'd1);
    @(negedge clk);
    z_arvalid = 0; z_awvalid = 0; z_wvalid = 0;
    check("z_rvalid", 32'(z_rvalid), 32'd1);
    check("z_bvalid2", 32'(z_bvalid), 32'd1);
    check("z_rdata_new", z_rdata, 32'h600D_F00D);
    check("z_rresp", 32'(z_rresp), 32'd0);
    @(negedge clk);
    check("z_arready_back", 32'(z_arready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
